// File: rtl/pueo_rackbus_cmd_engine.sv
// RACKBUS command decoder / run sequencer for TURFIO and SURF (sysclk domain).
// Decodes 32-bit rackbus command words into registered run-control strobes,
// tracks run state, counts PPS and buffers accepted trigger times in a
// first-word-fall-through FIFO with overflow and drop accounting.
// Optional build macro: RACKBUS_TRIG_SEQNUM_EN adds a 16-bit per-run trigger
// sequence number (trig_seq_o) stored alongside each FIFO entry.

// Fallback rackbus field layout, used when rackbus.vh has not been pulled in.
`ifndef RACKBUS_TRIG_BITS
`define RACKBUS_TRIG_BITS 15
`endif
`ifndef RACKBUS_IGNORE
`define RACKBUS_IGNORE(w) (w[31])
`endif
`ifndef RACKBUS_RUNCMD
`define RACKBUS_RUNCMD(w) (w[30:29])
`endif
`ifndef RACKBUS_PPS
`define RACKBUS_PPS(w) (w[28])
`endif
`ifndef RACKBUS_TRIG_VALID
`define RACKBUS_TRIG_VALID(w) (w[15])
`endif
`ifndef RACKBUS_TRIG
`define RACKBUS_TRIG(w) (w[`RACKBUS_TRIG_BITS-1:0])
`endif

module pueo_rackbus_cmd_engine #(
    parameter int unsigned TRIG_BITS       = `RACKBUS_TRIG_BITS,
    parameter int unsigned TRIG_FIFO_DEPTH = 16,
    parameter int unsigned RESET_HOLD      = 8,
    parameter int unsigned PPS_CNT_BITS    = 32,
    parameter int unsigned ERR_CNT_BITS    = 16
) (
    input  logic                    sysclk_i,
    input  logic                    sysclk_rst_i,
    input  logic [31:0]             command_i,
    input  logic                    command_valid_i,
    output logic                    sync_o,
    output logic                    reset_o,
    output logic                    stop_o,
    output logic                    run_reset_o,
    output logic                    running_o,
    output logic                    pps_o,
    output logic [PPS_CNT_BITS-1:0] pps_count_o,
    output logic [TRIG_BITS-1:0]    trig_time_o,
`ifdef RACKBUS_TRIG_SEQNUM_EN
    output logic [15:0]             trig_seq_o,
`endif
    output logic                    trig_valid_o,
    input  logic                    trig_ready_i,
    output logic                    trig_overflow_o,
    output logic [ERR_CNT_BITS-1:0] trig_drop_count_o,
    output logic [ERR_CNT_BITS-1:0] cmd_err_count_o,
    input  logic                    clear_errs_i
);

    localparam int unsigned AW = $clog2(TRIG_FIFO_DEPTH);
`ifdef RACKBUS_TRIG_SEQNUM_EN
    localparam int unsigned FW = TRIG_BITS + 16;
`else
    localparam int unsigned FW = TRIG_BITS;
`endif

    localparam logic [1:0] RUN_SYNC  = 2'd1;
    localparam logic [1:0] RUN_RESET = 2'd2;
    localparam logic [1:0] RUN_STOP  = 2'd3;

    localparam logic [7:0]              HOLD_INIT = 8'(RESET_HOLD - 1);
    localparam logic [ERR_CNT_BITS-1:0] ERR_ONE   = ERR_CNT_BITS'(1);
    localparam logic [PPS_CNT_BITS-1:0] PPS_ONE   = PPS_CNT_BITS'(1);
    localparam logic [AW:0]             PTR_ONE   = (AW + 1)'(1);

    typedef enum logic [1:0] {StIdle, StRunning, StResetting} state_e;

    state_e state_q, state_d;
    logic [7:0] hold_q, hold_d;
    logic sync_q, sync_d;
    logic reset_q, reset_d;
    logic stop_q, stop_d;
    logic pps_q, pps_d;
    logic [PPS_CNT_BITS-1:0] pps_cnt_q, pps_cnt_d;
    logic [ERR_CNT_BITS-1:0] err_cnt_q, err_cnt_d;
    logic [ERR_CNT_BITS-1:0] drop_cnt_q, drop_cnt_d;
    logic ovf_q, ovf_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [FW-1:0] mem_q [TRIG_FIFO_DEPTH];
    logic [FW-1:0] wr_data;
`ifdef RACKBUS_TRIG_SEQNUM_EN
    logic [15:0] seq_q, seq_d;
`endif

    logic [1:0] run_cmd;
    logic       cmd_sync, cmd_reset, cmd_stop;
    logic       err_inc;
    logic       trig_live, trig_accept, trig_drop;
    logic       fifo_full, fifo_empty;
    logic       push, pop, flush;
    logic [FW-1:0] head;

    // Bits of the command word that carry no field this block decodes.
    logic unused_cmd_bits;
    assign unused_cmd_bits = ^command_i[27:16];

    // Field decode: run commands need a live, non-ignored word.
    always_comb begin
        run_cmd   = 2'd0;
        if (command_valid_i && !`RACKBUS_IGNORE(command_i)) begin
            run_cmd = `RACKBUS_RUNCMD(command_i);
        end
        cmd_sync  = (run_cmd == RUN_SYNC);
        cmd_reset = (run_cmd == RUN_RESET);
        cmd_stop  = (run_cmd == RUN_STOP);
        pps_d     = command_valid_i & `RACKBUS_PPS(command_i);
        trig_live = command_valid_i & `RACKBUS_TRIG_VALID(command_i);
    end

    // Run-state FSM and run-control strobes; RESET overrides every state.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        sync_d  = 1'b0;
        reset_d = 1'b0;
        stop_d  = 1'b0;
        err_inc = 1'b0;
        if (cmd_reset) begin
            state_d = StResetting;
            hold_d  = HOLD_INIT;
            reset_d = 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    if (cmd_sync) begin
                        state_d = StRunning;
                        sync_d  = 1'b1;
                    end else if (cmd_stop) begin
                        err_inc = 1'b1;
                    end
                end
                StRunning: begin
                    if (cmd_stop) begin
                        state_d = StIdle;
                        stop_d  = 1'b1;
                    end else if (cmd_sync) begin
                        err_inc = 1'b1;
                    end
                end
                StResetting: begin
                    // Other run commands are silently ignored while holding.
                    if (hold_q == 8'd0) begin
                        state_d = StIdle;
                    end else begin
                        hold_d = hold_q - 8'd1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Trigger accept/drop uses the state before this word's run command.
    always_comb begin
        trig_accept = trig_live & (state_q == StRunning);
        trig_drop   = trig_live & (state_q != StRunning);
        fifo_empty  = (wr_ptr_q == rd_ptr_q);
        fifo_full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        // Fullness is judged before any same-cycle pop.
        push        = trig_accept & ~fifo_full;
        pop         = ~fifo_empty & trig_ready_i;
        flush       = cmd_reset;
        wr_ptr_d    = flush ? '0 : (push ? wr_ptr_q + PTR_ONE : wr_ptr_q);
        rd_ptr_d    = flush ? '0 : (pop ? rd_ptr_q + PTR_ONE : rd_ptr_q);
`ifdef RACKBUS_TRIG_SEQNUM_EN
        wr_data     = {seq_q, TRIG_BITS'(`RACKBUS_TRIG(command_i))};
        seq_d       = seq_q;
        if (sync_d || reset_d) begin
            seq_d = 16'd0;
        end else if (trig_accept) begin
            // Overflowed triggers still consume a number.
            seq_d = seq_q + 16'd1;
        end
`else
        wr_data     = TRIG_BITS'(`RACKBUS_TRIG(command_i));
`endif
    end

    // Error, drop, overflow and PPS counters; clear beats a same-cycle increment.
    always_comb begin
        err_cnt_d  = err_cnt_q;
        drop_cnt_d = drop_cnt_q;
        ovf_d      = ovf_q;
        pps_cnt_d  = pps_d ? pps_cnt_q + PPS_ONE : pps_cnt_q;
        if (clear_errs_i) begin
            err_cnt_d  = '0;
            drop_cnt_d = '0;
            ovf_d      = 1'b0;
        end else begin
            if (err_inc && !(&err_cnt_q)) begin
                err_cnt_d = err_cnt_q + ERR_ONE;
            end
            if (trig_drop && !(&drop_cnt_q)) begin
                drop_cnt_d = drop_cnt_q + ERR_ONE;
            end
            if (trig_accept && fifo_full) begin
                ovf_d = 1'b1;
            end
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge sysclk_i) begin
        if (sysclk_rst_i) begin
            state_q    <= StIdle;
            hold_q     <= '0;
            sync_q     <= 1'b0;
            reset_q    <= 1'b0;
            stop_q     <= 1'b0;
            pps_q      <= 1'b0;
            pps_cnt_q  <= '0;
            err_cnt_q  <= '0;
            drop_cnt_q <= '0;
            ovf_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
`ifdef RACKBUS_TRIG_SEQNUM_EN
            seq_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            sync_q     <= sync_d;
            reset_q    <= reset_d;
            stop_q     <= stop_d;
            pps_q      <= pps_d;
            pps_cnt_q  <= pps_cnt_d;
            err_cnt_q  <= err_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            ovf_q      <= ovf_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
`ifdef RACKBUS_TRIG_SEQNUM_EN
            seq_q      <= seq_d;
`endif
        end
    end

    // Trigger FIFO storage; contents need no reset since pointers gate them.
    always_ff @(posedge sysclk_i) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    // Output mapping; the head is masked so an empty FIFO reads as zero.
    always_comb begin
        head              = fifo_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
        trig_time_o       = head[TRIG_BITS-1:0];
`ifdef RACKBUS_TRIG_SEQNUM_EN
        trig_seq_o        = head[FW-1 -: 16];
`endif
        trig_valid_o      = ~fifo_empty;
        sync_o            = sync_q;
        reset_o           = reset_q;
        stop_o            = stop_q;
        pps_o             = pps_q;
        pps_count_o       = pps_cnt_q;
        run_reset_o       = (state_q == StResetting);
        running_o         = (state_q == StRunning);
        trig_overflow_o   = ovf_q;
        trig_drop_count_o = drop_cnt_q;
        cmd_err_count_o   = err_cnt_q;
    end

endmodule
